demux2_buf: RTL
===============

DEMUX2_BUF -- requirements
Module: demux2_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output queue (power of two, >= 2).
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: d  input  WIDTH  input data word.
REQ-006 SHALL have port: s  input  1  destination select; 0 routes to y0, 1 routes to y1.
REQ-007 SHALL have port: in_valid  input  1  d/s valid this cycle.
REQ-008 SHALL have port: in_ready  output  1  block accepts d this cycle.
REQ-009 SHALL have ports: y0, y1  output  WIDTH  head-of-queue data per destination.
REQ-010 SHALL have ports: y0_valid, y1_valid  output  1  y0/y1 hold a valid word.
REQ-011 SHALL have ports: y0_ready, y1_ready  input  1  consumer accepts y0/y1.
REQ-012 SHALL have ports: cnt0, cnt1  output  16  words accepted for port 0/1.

Function
REQ-013 SHALL accept a word when in_valid && in_ready on a rising clk edge.
REQ-014 SHALL drive in_ready = NOT full(queue selected by s), combinationally from s and occupancy.
REQ-015 SHALL push an accepted word into queue s only; the other queue is unaffected.
REQ-016 SHALL present a pushed word on y<s> with y<s>_valid=1 exactly one cycle after acceptance when the queue was empty (no combinational d->y path).
REQ-017 SHALL drive yN_valid = NOT empty(queue N); yN = queue N head word.
REQ-018 SHALL pop queue N when yN_valid && yN_ready on a rising edge.
REQ-019 SHALL hold yN and yN_valid stable while yN_valid=1 and yN_ready=0.
REQ-020 SHALL preserve arrival order within each queue; no ordering between queues.
REQ-021 SHALL, on simultaneous push and pop of the same non-full queue, keep occupancy unchanged and perform both.
REQ-022 SHALL, with queue full, deassert in_ready for that s even if a pop occurs that cycle (no full-bypass).
REQ-023 SHALL ignore yN_ready while yN_valid=0 (no underflow, pointers unchanged).
REQ-024 SHALL wrap read/write pointers modulo DEPTH.
REQ-025 SHALL increment cntN by 1 per accepted word to port N, saturating at 16'hFFFF.
REQ-026 SHALL treat s as don't-care when in_valid=0.

Reset
REQ-027 SHALL, when rst=1 at a rising edge, clear both queues (pointers and occupancy 0), cnt0=cnt1=0, y0_valid=y1_valid=0, y0=y1=0.
REQ-028 SHALL discard all queued words on reset mid-operation; an input handshake in the reset cycle is not accepted.
REQ-029 SHALL hold in_ready=0 while rst=1.

Structure
REQ-030 SHALL place WIDTH/DEPTH defaults and counter width (16) as constants in shared package demux2_pkg.
REQ-031 SHALL implement each queue as one instance of sub-module fifo_sync (push/pop/full/empty/head), instantiated twice.
REQ-032 SHALL keep counters and select/steering logic in demux2_buf top.

Verification
REQ-033 Reset then d=32'hDEADBEEF, s=0, in_valid=1 one cycle, y0_ready=1 -> y0=32'hDEADBEEF, y0_valid=1 next cycle, y1_valid=0, cnt0=1.
REQ-034 y1_ready=0; push 32'h1, 32'h2 with s=1 -> in_ready=0 for s=1, in_ready=1 for s=0; y1 holds 32'h1; after y1_ready=1 outputs 32'h1 then 32'h2.
REQ-035 Queue 0 full, pop and push offered same cycle -> push refused, occupancy drops to 1, next cycle push accepted.
REQ-036 Alternate s=0/1 pushing 32'hA0..32'hA7 with both readies=1 -> y0 sees A0,A2,A4,A6; y1 sees A1,A3,A5,A7; cnt0=cnt1=4.
REQ-037 rst=1 with both queues full and cnt0=5 -> next cycle y0_valid=y1_valid=0, cnt0=cnt1=0, in_ready=1 after rst=0.
REQ-038 Force cnt1 to 16'hFFFE, accept 3 words to port 1 -> cnt1=16'hFFFF (saturated).

Source files
------------

// File: rtl/demux2_pkg.sv
// Shared constants and helpers for the buffered 1-to-2 demultiplexer.
package demux2_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned CNT_W     = 16;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CNT_MAX = '1;

  function automatic cnt_t sat_inc(input cnt_t c, input logic en);
    return (en && (c != CNT_MAX)) ? c + cnt_t'(1) : c;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered head; push when full and pop when empty are ignored.
module fifo_sync #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push, do_pop;

  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (do_pop && !do_push) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/demux2_buf.sv
// Buffered 1-to-2 demultiplexer: steers each accepted word into the queue chosen by s
// and counts accepted words per destination.
module demux2_buf
  import demux2_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic             y0_valid,
  output logic             y1_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  logic full0, full1, empty0, empty1;
  logic push0, push1, accept;
  cnt_t cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  always_comb begin
    in_ready = !rst && !(s ? full1 : full0);
    accept   = in_valid && in_ready;
    push0    = accept && !s;
    push1    = accept && s;
    cnt0_d   = sat_inc(cnt0_q, push0);
    cnt1_d   = sat_inc(cnt1_q, push1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .wdata (d),
    .pop   (y0_ready),
    .full  (full0),
    .empty (empty0),
    .head  (y0)
  );

  fifo_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_q1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .wdata (d),
    .pop   (y1_ready),
    .full  (full1),
    .empty (empty1),
    .head  (y1)
  );

  assign y0_valid = !empty0;
  assign y1_valid = !empty1;
  assign cnt0     = cnt0_q;
  assign cnt1     = cnt1_q;

endmodule
